// File: rtl/svm_seq_engine_if.sv
// Handshake bundle between the SVM picker (master) and the sequential evaluator (slave).
// The picker drives the vector, start request and current weight/bias pair.
interface svm_seq_engine_if #(
  parameter int N_features  = 11,
  parameter int inputWidth  = 4,
  parameter int weightWidth = 8,
  parameter int biasWidth   = 12
) ();

  logic                              start;
  logic [inputWidth*N_features-1:0]  features;
  logic [weightWidth*N_features-1:0] weight;
  logic [biasWidth-1:0]              bia;
  logic                              w_class;
  logic                              svmready;
  logic                              busy;

  modport master (
    output start, features, weight, bia,
    input  w_class, svmready, busy
  );

  modport slave (
    input  start, features, weight, bia,
    output w_class, svmready, busy
  );

endinterface

// File: rtl/svm_seq_engine.sv
// Sequential one-vs-one SVM evaluator: one feature-times-weight MAC per cycle,
// N_CLASSES-1 back-to-back decisions per captured feature vector.
module svm_seq_engine #(
  parameter int N_features  = 11,
  parameter int inputWidth  = 4,
  parameter int weightWidth = 8,
  parameter int biasWidth   = 12,
  parameter int N_CLASSES   = 6
) (
  input logic          clk,
  input logic          rst_n,
  svm_seq_engine_if.slave bus
);

  localparam int PROD_W = inputWidth + weightWidth + 1;
  localparam int ACC_W  = PROD_W + $clog2(N_features) + 1;
  localparam int IDX_W  = (N_features > 1) ? $clog2(N_features) : 1;
  localparam int CNT_W  = (N_CLASSES > 2) ? $clog2(N_CLASSES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_features - 1);
  localparam logic [CNT_W-1:0] LAST_EVAL = CNT_W'(N_CLASSES - 2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    DECIDE = 2'd2
  } state_t;

  state_t                        state_q, state_d;
  logic [inputWidth*N_features-1:0] feat_q, feat_d;
  logic signed [ACC_W-1:0]       acc_q, acc_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          w_class_q, w_class_d;
  logic                          svmready_q, svmready_d;
  logic                          busy_q, busy_d;

  logic [inputWidth-1:0]         feat_slice;
  logic [weightWidth-1:0]        weight_slice;
  logic signed [PROD_W-1:0]      feat_ext;
  logic signed [PROD_W-1:0]      weight_ext;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       prod_ext;
  logic signed [ACC_W-1:0]       bia_ext;

  // Features are unsigned, so they get a zero MSB before the signed multiply.
  assign feat_slice   = feat_q[idx_q*inputWidth +: inputWidth];
  assign weight_slice = bus.weight[idx_q*weightWidth +: weightWidth];
  assign feat_ext     = {{(PROD_W-inputWidth){1'b0}}, feat_slice};
  assign weight_ext   = {{(PROD_W-weightWidth){weight_slice[weightWidth-1]}}, weight_slice};
  assign prod         = feat_ext * weight_ext;
  assign prod_ext     = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  assign bia_ext      = {{(ACC_W-biasWidth){bus.bia[biasWidth-1]}}, bus.bia};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      feat_q     <= '0;
      acc_q      <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      w_class_q  <= 1'b0;
      svmready_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      feat_q     <= feat_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      w_class_q  <= w_class_d;
      svmready_q <= svmready_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    feat_d     = feat_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    w_class_d  = w_class_q;
    svmready_d = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          feat_d  = bus.features;
          acc_d   = bia_ext;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = MAC;
        end
      end

      MAC: begin
        // The bias is re-taken on the first MAC cycle: the picker only swaps
        // to the next pair on the edge that ends DECIDE, after the reload.
        acc_d = ((idx_q == '0) ? bia_ext : acc_q) + prod_ext;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          w_class_d  = ~acc_d[ACC_W-1];
          svmready_d = 1'b1;
          state_d    = DECIDE;
        end
      end

      DECIDE: begin
        cnt_d = cnt_q + CNT_W'(1);
        idx_d = '0;
        if (cnt_q == LAST_EVAL) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d   = bia_ext;
          state_d = MAC;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.w_class  = w_class_q;
  assign bus.svmready = svmready_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_svm_seq_engine.sv
// Self-checking bench: directed and randomized vectors against a plain-arithmetic
// one-vs-one DAG model that plays the picker role around the engine.
module tb_svm_seq_engine;

  localparam int NF   = 11;
  localparam int IW   = 4;
  localparam int WW   = 8;
  localparam int BW   = 12;
  localparam int NC   = 6;
  localparam int NEV  = NC - 1;
  localparam int EVC  = NF + 1;
  localparam int RUNC = NEV * EVC;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  svm_seq_engine_if #(.N_features(NF), .inputWidth(IW), .weightWidth(WW), .biasWidth(BW)) bus ();

  svm_seq_engine #(
    .N_features(NF), .inputWidth(IW), .weightWidth(WW), .biasWidth(BW), .N_CLASSES(NC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  int featV [NF];
  int pairW [NC][NC][NF];
  int pairB [NC][NC];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Decision value straight from the one-vs-one rule: bias plus dot product.
  function automatic int modelAcc(input int lo, input int hi);
    int acc;
    acc = pairB[lo][hi];
    for (int i = 0; i < NF; i++) acc += featV[i] * pairW[lo][hi][i];
    return acc;
  endfunction

  task automatic driveInputs(input int lo, input int hi);
    logic [IW*NF-1:0] f;
    logic [WW*NF-1:0] w;
    for (int i = 0; i < NF; i++) begin
      f[i*IW +: IW] = IW'(featV[i]);
      w[i*WW +: WW] = WW'(pairW[lo][hi][i]);
    end
    bus.features = f;
    bus.weight   = w;
    bus.bia      = BW'(pairB[lo][hi]);
  endtask

  task automatic fillPairs(input int w0, input int wRest, input int b);
    for (int a = 0; a < NC; a++)
      for (int c = 0; c < NC; c++) begin
        pairB[a][c] = b;
        for (int i = 0; i < NF; i++) pairW[a][c][i] = (i == 0) ? w0 : wRest;
      end
  endtask

  task automatic randomFeatures();
    for (int i = 0; i < NF; i++) featV[i] = int'($urandom_range(15));
  endtask

  task automatic randomInputs();
    logic [63:0] r2;
    logic [95:0] r3;
    r2 = {$urandom(), $urandom()};
    r3 = {$urandom(), $urandom(), $urandom()};
    bus.start    = r2[63];
    bus.features = r2[IW*NF-1:0];
    bus.weight   = r3[WW*NF-1:0];
    bus.bia      = r3[95 -: BW];
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " svmready"}, 32'(bus.svmready), 0);
    checkOutput({tag, " w_class"},  32'(bus.w_class),  0);
    checkOutput({tag, " busy"},     32'(bus.busy),     0);
  endtask

  // One full vector, called at a negedge. The picker side advances on the DUT's
  // decisions; expDec/expWinner < 0 and midStart/resetAt == 0 disable those extras.
  task automatic applyStimulus(input string name, input int expDec, input int expWinner,
                               input int midStart, input int resetAt);
    int lo, hi, pulses, expPulse, acc;
    lo = 0;
    hi = NC - 1;
    pulses = 0;
    driveInputs(lo, hi);
    bus.start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= RUNC + 1; k++) begin
      @(negedge clk);
      bus.start = (k == midStart);
      if (k == midStart) bus.features = ~bus.features;
      if (k == resetAt) begin
        rst_n = 1'b0;
        #1;
        checkIdleOutputs($sformatf("%s reset c%0d", name, k));
        return;
      end
      expPulse = ((k % EVC) == 0 && k <= RUNC) ? 1 : 0;
      checkOutput($sformatf("%s svmready c%0d", name, k), 32'(bus.svmready), expPulse);
      checkOutput($sformatf("%s busy c%0d", name, k), 32'(bus.busy), (k <= RUNC) ? 1 : 0);
      if (bus.svmready === 1'b1) pulses++;
      if (expPulse == 1) begin
        acc = modelAcc(lo, hi);
        checkOutput($sformatf("%s w_class pair%0d_%0d", name, lo, hi), 32'(bus.w_class),
                    (acc >= 0) ? 1 : 0);
        if (expDec >= 0)
          checkOutput($sformatf("%s w_class const c%0d", name, k), 32'(bus.w_class), expDec);
        if (bus.w_class === 1'b1) hi--;
        else lo++;
        if (k < RUNC) begin
          @(posedge clk);
          #1;
          driveInputs(lo, hi);
        end
      end
    end
    checkOutput({name, " pulse count"}, 32'(pulses), NEV);
    if (expWinner >= 0) checkOutput({name, " winner"}, 32'(lo), expWinner);
  endtask

  initial begin
    rst_n = 1'b0;
    randomInputs();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      randomInputs();
      #1;
      checkIdleOutputs($sformatf("hold reset %0d", c));
    end
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdleOutputs($sformatf("post reset %0d", c));
    end

    $display("[TB] sign boundary");
    randomFeatures();
    fillPairs(0, 0, 0);
    applyStimulus("zero_bias", 1, -1, 0, 0);
    fillPairs(0, 0, -1);
    applyStimulus("minus_one_bias", 0, -1, 0, 0);

    $display("[TB] single-feature MAC");
    randomFeatures();
    featV[0] = 15;
    fillPairs(-8, 0, 100);
    applyStimulus("single_neg", 0, -1, 0, 0);
    fillPairs(-8, 0, 120);
    applyStimulus("single_zero", 1, -1, 0, 0);

    $display("[TB] extreme magnitude");
    for (int i = 0; i < NF; i++) featV[i] = 15;
    fillPairs(-128, -128, -2048);
    applyStimulus("extreme_neg", 0, -1, 0, 0);
    fillPairs(127, 127, 2047);
    applyStimulus("extreme_pos", 1, -1, 0, 0);

    $display("[TB] random vectors");
    for (int v = 0; v < 3; v++) begin
      randomFeatures();
      for (int a = 0; a < NC; a++)
        for (int c = 0; c < NC; c++) begin
          pairB[a][c] = int'($urandom_range(4095)) - 2048;
          for (int i = 0; i < NF; i++) pairW[a][c][i] = int'($urandom_range(255)) - 128;
        end
      applyStimulus($sformatf("random%0d", v), -1, -1, int'($urandom_range(59, 2)), 0);
    end

    $display("[TB] closed loop toward class 3");
    randomFeatures();
    for (int a = 0; a < NC; a++)
      for (int c = 0; c < NC; c++) begin
        for (int i = 0; i < NF; i++) pairW[a][c][i] = int'($urandom_range(15)) - 8;
        if (a == 3)      pairB[a][c] = 2047;
        else if (c == 3) pairB[a][c] = -2048;
        else if (a < 3)  pairB[a][c] = -2048;
        else             pairB[a][c] = 2047;
      end
    applyStimulus("closed_loop", -1, 3, 30, 0);

    $display("[TB] mid-run reset");
    randomFeatures();
    fillPairs(0, 0, 0);
    applyStimulus("mid_reset", 1, -1, 0, 2 * EVC + 3);
    @(negedge clk);
    checkIdleOutputs("reset held");
    rst_n = 1'b1;
    @(negedge clk);
    randomFeatures();
    for (int a = 0; a < NC; a++)
      for (int c = 0; c < NC; c++) begin
        pairB[a][c] = int'($urandom_range(4095)) - 2048;
        for (int i = 0; i < NF; i++) pairW[a][c][i] = int'($urandom_range(255)) - 128;
      end
    applyStimulus("after_reset", -1, -1, 0, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
